// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 fetch/dispatch slice.
//   opcode_e : 4-bit LC-3 opcodes (ir[15:12])
//   state_e  : sequencer states
//   HALT_INSTR, DEFAULT_RESET_PC, req_onehot() helper
package lc3_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'd0,  OP_ADD = 4'd1,  OP_LD   = 4'd2,  OP_ST   = 4'd3,
    OP_JSR  = 4'd4,  OP_AND = 4'd5,  OP_LDR  = 4'd6,  OP_STR  = 4'd7,
    OP_RTI  = 4'd8,  OP_NOT = 4'd9,  OP_LDI  = 4'd10, OP_STI  = 4'd11,
    OP_JMP  = 4'd12, OP_RES = 4'd13, OP_LEA  = 4'd14, OP_TRAP = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_e;

  localparam logic [15:0] HALT_INSTR       = 16'hF025;
  localparam logic [15:0] DEFAULT_RESET_PC = 16'h3000;

  // One-hot execute-unit request for an opcode.
  function automatic logic [15:0] req_onehot(input opcode_e op);
    logic [15:0] r;
    r = '0;
    r[op] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/lc3_fetch_dispatch_if.sv
// Instruction-fetch memory bus.
//   addr  : fetch address (master -> slave)
//   rd    : fetch request, held until ready (master -> slave)
//   rdata : fetched word, valid with ready (slave -> master)
//   ready : slave accepts and returns data this cycle (slave -> master)
interface lc3_mem_if;
  logic [15:0] addr;
  logic        rd;
  logic [15:0] rdata;
  logic        ready;

  modport master (output addr, rd, input rdata, ready);
  modport slave  (input addr, rd, output rdata, ready);
endinterface

// File: rtl/lc3_cc_reg.sv
// NZP condition-code register.
//   clk, rst     : clock, synchronous active-high reset (resets to Z)
//   we, value    : load NZP derived from value when we=1
//   n, z, p      : condition codes, exactly one set at all times
module lc3_cc_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [15:0] value,
  output logic        n,
  output logic        z,
  output logic        p
);

  always_ff @(posedge clk) begin
    if (rst) begin
      n <= 1'b0;
      z <= 1'b1;
      p <= 1'b0;
    end else if (we) begin
      n <= value[15];
      z <= (value == 16'h0000);
      p <= !value[15] && (value != 16'h0000);
    end
  end

endmodule

// File: rtl/lc3_fetch_dispatch.sv
// LC-3 fetch/decode/dispatch sequencer.
//   clk, rst      : clock, synchronous active-high reset
//   mem           : fetch bus (master side)
//   ir, pc        : instruction register, program counter (pc+1 once fetched)
//   exec_req      : one-hot start request to the execute unit, high in EXEC
//   exec_done     : unit finished (EXEC only)
//   pc_load_en/val: PC redirect from the unit (EXEC only)
//   cc_we/value   : condition-code update from the unit (EXEC only)
//   n, z, p       : condition codes
//   halted        : HALT decoded, core stopped until reset
//   illegal       : sticky, reserved opcode decoded
module lc3_fetch_dispatch
  import lc3_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  lc3_mem_if.master   mem,
  output logic [15:0] ir,
  output logic [15:0] pc,
  output logic [15:0] exec_req,
  input  logic        exec_done,
  input  logic        pc_load_en,
  input  logic [15:0] pc_load_val,
  input  logic        cc_we,
  input  logic [15:0] cc_value,
  output logic        n,
  output logic        z,
  output logic        p,
  output logic        halted,
  output logic        illegal
);

  state_e  state, state_nxt;
  opcode_e op;

  assign op = opcode_e'(ir[15:12]);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_FETCH:  if (mem.ready) state_nxt = S_DECODE;
      S_DECODE: begin
        if (ir == HALT_INSTR)  state_nxt = S_HALT;
        else if (op == OP_RES) state_nxt = S_FETCH;
        else                   state_nxt = S_EXEC;
      end
      S_EXEC:   if (exec_done) state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // Outputs. Request and fetch strobe are gated by rst so they drop in the
  // reset cycle itself rather than one edge later.
  always_comb begin
    mem.addr = pc;
    mem.rd   = (state == S_FETCH) && !rst;
    exec_req = '0;
    if (state == S_EXEC && !rst) exec_req = req_onehot(op);
    halted   = (state == S_HALT);
  end

  // PC / IR / illegal flag
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      ir      <= '0;
      illegal <= 1'b0;
    end else begin
      unique case (state)
        S_FETCH: if (mem.ready) begin
          ir <= mem.rdata;
          pc <= pc + 16'd1;
        end
        S_DECODE: if (op == OP_RES && ir != HALT_INSTR) illegal <= 1'b1;
        S_EXEC:   if (pc_load_en) pc <= pc_load_val;
        default:  ;
      endcase
    end
  end

  lc3_cc_reg u_cc (
    .clk   (clk),
    .rst   (rst),
    .we    (cc_we && state == S_EXEC),
    .value (cc_value),
    .n     (n),
    .z     (z),
    .p     (p)
  );

endmodule

// File: doc/lc3_fetch_dispatch.md
# lc3_fetch_dispatch

Fetch/decode/dispatch sequencer for the LC-3 core, directly upstream of the per-opcode execute units such as the branch unit. It fetches the word at PC into IR, increments PC and decodes the opcode. It then raises that opcode's one-hot request, which the unit reads as its start flag, and waits for the unit's done. It also owns the NZP condition-code register that the branch unit reads.

## Interface
Parameters:
- RESET_PC, 16'h3000, PC value loaded on reset.

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- mem_addr  out  16  fetch address, equals pc
- mem_rd  out  1  fetch request, held until mem_ready
- mem_rdata  in  16  fetched word, valid when mem_ready=1
- mem_ready  in  1  memory accepts and returns data this cycle
- ir  out  16  current instruction register
- pc  out  16  program counter, already incremented during EXEC
- exec_req  out  16  one-hot request; bit index = ir[15:12], held high through EXEC
- exec_done  in  1  execute unit finished, sampled only in EXEC
- pc_load_en  in  1  execute unit redirects PC, honoured only in EXEC
- pc_load_val  in  16  new PC value
- cc_we  in  1  write condition codes, honoured only in EXEC
- cc_value  in  16  result value from which NZP is derived
- n, z, p  out  1 each  condition codes
- halted  out  1  HALT (TRAP x25) decoded, core stopped
- illegal  out  1  sticky, reserved opcode 4'b1101 decoded

## Operation
- States: FETCH, DECODE, EXEC, HALT.
- Reset: state=FETCH, pc=RESET_PC, ir=0, exec_req=0, mem_rd=0, halted=0, illegal=0, n=0 z=1 p=0.
- FETCH:
  - mem_rd=1 and mem_addr=pc, both stable until mem_ready.
  - On mem_ready: ir<=mem_rdata, pc<=pc+1 (16-bit wrap, FFFF→0000), go to DECODE.
- DECODE:
  - ir==16'hF025: halted<=1, go to HALT, no request raised.
  - ir[15:12]==4'b1101: illegal<=1, go to FETCH, no request raised.
  - Otherwise go to EXEC.
- EXEC:
  - exec_req = 1<<ir[15:12], held high throughout.
  - pc_load_en: pc<=pc_load_val.
  - cc_we: n=cc_value[15]; z=(cc_value==0); p=otherwise. Exactly one of n/z/p is set.
  - exec_done: go to FETCH; exec_req drops in the next cycle.
- HALT: all requests 0, pc and ir frozen; left only by rst.
- mem_rd=0 in DECODE, EXEC and HALT.

## Timing
- mem_ready in the same cycle as mem_rd gives a 1-cycle FETCH. The fastest instruction takes 3 cycles (FETCH, DECODE, EXEC with exec_done=1 in its first cycle).
- exec_req goes high on the edge that enters EXEC and low on the edge that leaves it. Units must see a rising edge for each instruction, so at least one cycle with exec_req low separates back-to-back requests.
- pc_load_en together with exec_done in the same cycle: the load applies, and the next FETCH uses pc_load_val.
- cc_we together with exec_done in the same cycle: the CC update applies.
- pc_load_en, cc_we or exec_done outside EXEC: ignored.
- rst in any state, including mid-FETCH with mem_rd high or mid-EXEC: reset values take effect next cycle, and exec_req drops immediately.
- mem_rdata is ignored when mem_ready=0.

## Structure
- Package lc3_pkg:
  - opcode enum (OP_BR=0 … OP_TRAP=15, OP_RES=13)
  - state enum
  - HALT_INSTR=16'hF025
  - default RESET_PC
- Sub-module lc3_cc_reg: NZP register with we/value inputs and reset to Z.
- The FSM, PC and IR stay in the top module.

## Test plan
- Reset, then mem_ready=1 every cycle and mem_rdata=16'h1021 (ADD): mem_addr=3000 on the first FETCH; next cycle ir=1021 and pc=3001; then exec_req=16'h0002 until exec_done.
- Branch redirect: BR instruction 16'h0E05 gives exec_req=16'h0001. Pulse pc_load_en with pc_load_val=16'h3010 in the same cycle as exec_done → next mem_addr=3010.
- CC: in EXEC apply cc_we with cc_value=0 → z=1. With 16'h8000 → n=1. With 16'h0001 → p=1. Asserting cc_we in FETCH leaves NZP unchanged.
- Wait states: hold mem_ready=0 for 4 cycles → mem_rd and mem_addr stay stable and ir is unchanged. Fetch at pc=FFFF → pc wraps to 0000.
- Special decodes: mem_rdata=16'hD000 → illegal=1 sticky, no exec_req, next fetch at pc+1. mem_rdata=16'hF025 → halted=1, mem_rd=0 thereafter.
- Reset mid-EXEC: assert rst while exec_req=16'h0040 → next cycle exec_req=0, pc=3000, z=1, state FETCH.
